// File: rtl/inst_axi_pkg.sv
// Shared types and AXI encodings for the instruction-side AXI read master.
package inst_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } AXI_RD_STATE_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned BURST_LEN_DEF  = 32'd4;

  // Cache lines are 16-byte aligned; the low nibble of a fill address is dropped.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFF0;
  endfunction

endpackage

// File: rtl/axi_inst_read_master_chk.sv
// Protocol checker for axi_inst_read_master: flags fill requests while busy and
// R beats carrying a foreign ID.
module axi_inst_read_master_chk #(
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input logic            clk_i,
  input logic            rst_i,
  input logic            req_i,
  input logic            busy_i,
  input logic            rd_hs_i,
  input logic [ID_W-1:0] rid_i
);

  req_while_busy_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(req_i && busy_i));

  rid_match_a: assert property (@(posedge clk_i) disable iff (rst_i)
    rd_hs_i |-> (rid_i == ID_W'(AXI_ID)));

endmodule

// File: rtl/axi_inst_read_master.sv
// I$ line-fill to single AXI4 INCR read burst converter (read channels only).
// Optional INST_AXI_PERF_EN adds simulation fill/beat/latency counters.
module axi_inst_read_master
  import inst_axi_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ID_W      = 4,
  parameter int AXI_ID    = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [31:0]     addr_i,
  output logic            wait_o,
  output logic            out_valid_o,
  output logic [31:0]     out_o,
  output logic [31:0]     araddr_o,
  output logic [ID_W-1:0] arid_o,
  output logic [3:0]      arlen_o,
  output logic [2:0]      arsize_o,
  output logic [1:0]      arburst_o,
  output logic            arvalid_o,
  input  logic            arready_i,
  input  logic [ID_W-1:0] rid_i,
  input  logic [31:0]     rdata_i,
  input  logic [1:0]      rresp_i,
  input  logic            rlast_i,
  input  logic            rvalid_i,
  output logic            rready_o,
  output logic            err_o
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  AXI_RD_STATE_t    state_r;
  logic [31:0]      araddr_r;
  logic             arvalid_r;
  logic             rready_r;
  logic             out_valid_r;
  logic [31:0]      out_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic             err_r;
  logic             ar_hs_s;
  logic             rd_hs_s;

  assign ar_hs_s = arvalid_r & arready_i;
  assign rd_hs_s = rvalid_i & rready_r;

  assign arid_o      = ID_W'(AXI_ID);
  assign arlen_o     = 4'(BURST_LEN - 1);
  assign arsize_o    = AXI_SIZE_WORD;
  assign arburst_o   = AXI_BURST_INCR;
  assign araddr_o    = araddr_r;
  assign arvalid_o   = arvalid_r;
  assign rready_o    = rready_r;
  assign out_valid_o = out_valid_r;
  assign out_o       = out_r;
  assign err_o       = err_r;
  // Stays high through the cycle carrying the last word so the I$ never drops it.
  assign wait_o      = req_i | (state_r != IDLE) | out_valid_r;

  // Fill sequencer: AR issue, R beat capture, beat counting and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      araddr_r    <= 32'h0000_0000;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_r       <= 32'h0000_0000;
      beat_cnt_r  <= '0;
      err_r       <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_i) begin
            araddr_r  <= line_align(addr_i);
            arvalid_r <= 1'b1;
            state_r   <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs_s) begin
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b1;
            beat_cnt_r <= '0;
            state_r    <= DATA;
          end
        end
        DATA: begin
          if (rd_hs_s) begin
            out_r       <= rdata_i;
            out_valid_r <= 1'b1;
            beat_cnt_r  <= (beat_cnt_r == LAST_BEAT) ? '0 : beat_cnt_r + CNT_W'(1);
            if (rresp_i != AXI_RESP_OKAY) begin
              err_r <= 1'b1;
            end
            // Early RLAST ends the burst; a missing RLAST keeps the channel open.
            if (rlast_i) begin
              rready_r <= 1'b0;
              state_r  <= IDLE;
              if (beat_cnt_r != LAST_BEAT) begin
                err_r <= 1'b1;
              end
            end else if (beat_cnt_r == LAST_BEAT) begin
              err_r <= 1'b1;
            end
          end
        end
        default: begin
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  axi_inst_read_master_chk #(
    .ID_W   (ID_W),
    .AXI_ID (AXI_ID)
  ) u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .busy_i  (state_r != IDLE),
    .rd_hs_i (rd_hs_s),
    .rid_i   (rid_i)
  );

`ifdef INST_AXI_PERF_EN
  int unsigned perf_fills_r;
  int unsigned perf_beats_r;
  int unsigned perf_wait_cycles_r;

  // Fill, beat and busy-cycle counters for simulation reporting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fills_r       <= 32'd0;
      perf_beats_r       <= 32'd0;
      perf_wait_cycles_r <= 32'd0;
    end else begin
      if (ar_hs_s) begin
        perf_fills_r <= perf_fills_r + 32'd1;
      end
      if (rd_hs_s) begin
        perf_beats_r <= perf_beats_r + 32'd1;
      end
      if (wait_o) begin
        perf_wait_cycles_r <= perf_wait_cycles_r + 32'd1;
      end
    end
  end

  final begin
    $display("axi_inst_read_master perf: fills=%0d beats=%0d avg_fill_latency=%0d",
             perf_fills_r, perf_beats_r,
             (perf_fills_r == 32'd0) ? 32'd0 : perf_wait_cycles_r / perf_fills_r);
  end
`endif

endmodule

// File: tb/tb_axi_inst_read_master.sv
// Directed scoreboard bench for axi_inst_read_master: stimulus queues expected
// words/addresses, a negedge monitor pops and compares them.
module tb_axi_inst_read_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic [31:0] addr_i;
  logic        wait_o;
  logic        out_valid_o;
  logic [31:0] out_o;
  logic [31:0] araddr_o;
  logic [3:0]  arid_o;
  logic [3:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [3:0]  rid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic        rvalid_i;
  logic        rready_o;
  logic        err_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ar_q[$];
  logic [31:0] mon_exp;
  logic        busy_chk = 1'b0;
  logic        exp_err  = 1'b0;

  axi_inst_read_master dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i),
    .wait_o(wait_o), .out_valid_o(out_valid_o), .out_o(out_o),
    .araddr_o(araddr_o), .arid_o(arid_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o), .arvalid_o(arvalid_o),
    .arready_i(arready_i), .rid_i(rid_i), .rdata_i(rdata_i),
    .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: returned words, AR handshakes, and wait_o while busy.
  always @(negedge clk_i) begin
    if (out_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL word_extra: got 0x%08h, expected no word", out_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("word", out_o, mon_exp);
      end
    end
    if (arvalid_o && arready_i) begin
      if (ar_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ar_extra: got araddr 0x%08h, expected no request", araddr_o);
      end else begin
        mon_exp = ar_q.pop_front();
        check("ar_addr", araddr_o, mon_exp);
      end
    end
    if (busy_chk) check("wait_busy", {31'd0, wait_o}, 32'd1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill(input logic [31:0] addr, input logic [31:0] base,
                      input int ar_stall, input bit gap, input int nbeats,
                      input int err_beat, input bit abort, input bit chk_lat,
                      input bit chk_busy);
    int          c0;
    int          n;
    int          last_hi;
    logic        ovl;
    logic        err0;
    logic [31:0] line;
    line = addr & 32'hFFFF_FFF0;
    err0 = exp_err;
    c0   = cyc;
    req_i     = 1'b1;
    addr_i    = addr;
    arready_i = (ar_stall == 0);
    busy_chk  = chk_busy;
    ar_q.push_back(line);
    tick();
    req_i = 1'b0;
    @(negedge clk_i);
    check("ar_valid_next", {31'd0, arvalid_o}, 32'd1);
    check("ar_addr_latched", araddr_o, line);
    for (int s = 1; s < ar_stall; s++) begin
      tick();
      @(negedge clk_i);
      check("ar_valid_stall", {31'd0, arvalid_o}, 32'd1);
      check("ar_addr_stall", araddr_o, line);
      check("rready_stall", {31'd0, rready_o}, 32'd0);
    end
    if (ar_stall > 0) begin
      tick();
      arready_i = 1'b1;
    end
    tick();
    arready_i = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (gap && b > 0) begin
        rvalid_i = 1'b0;
        tick();
      end
      rvalid_i = 1'b1;
      rdata_i  = base + 32'(b);
      rresp_i  = (b == err_beat) ? 2'b10 : 2'b00;
      rlast_i  = (b == nbeats - 1) && !abort;
      exp_q.push_back(base + 32'(b));
      @(negedge clk_i);
      n = 0;
      while (!rready_o && n < 8) begin
        @(negedge clk_i);
        n++;
      end
      check("rready_seen", {31'd0, rready_o}, 32'd1);
      check("err_during", {31'd0, err_o}, {31'd0, err0 | (err_beat >= 0 && b > err_beat)});
      tick();
    end
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    rresp_i  = 2'b00;
    busy_chk = 1'b0;
    if (abort) begin
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      exp_err = 1'b0;
      @(negedge clk_i);
      check("rst_arvalid", {31'd0, arvalid_o}, 32'd0);
      check("rst_rready", {31'd0, rready_o}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_out", out_o, 32'd0);
      check("rst_araddr", araddr_o, 32'd0);
      check("rst_err", {31'd0, err_o}, 32'd0);
      check("rst_wait", {31'd0, wait_o}, 32'd0);
      return;
    end
    exp_err = exp_err | (err_beat >= 0) | (nbeats != 4);
    n = 0;
    last_hi = -1;
    ovl = 1'b0;
    @(negedge clk_i);
    while (wait_o && n < 20) begin
      last_hi = cyc - c0;
      ovl = out_valid_o;
      @(negedge clk_i);
      n++;
    end
    check("wait_fall", {31'd0, wait_o}, 32'd0);
    if (chk_lat) begin
      check("last_word_cycle", 32'(last_hi), 32'd6);
      check("wait_with_last_word", {31'd0, ovl}, 32'd1);
    end
    check("idle_arvalid", {31'd0, arvalid_o}, 32'd0);
    check("idle_rready", {31'd0, rready_o}, 32'd0);
    check("err_after", {31'd0, err_o}, {31'd0, exp_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; req_i = 1'b0; addr_i = 32'd0; arready_i = 1'b0;
    rid_i = 4'd0; rdata_i = 32'd0; rresp_i = 2'b00; rlast_i = 1'b0; rvalid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_arvalid", {31'd0, arvalid_o}, 32'd0);
    check("reset_rready", {31'd0, rready_o}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("reset_out", out_o, 32'd0);
    check("reset_araddr", araddr_o, 32'd0);
    check("reset_err", {31'd0, err_o}, 32'd0);
    check("reset_wait", {31'd0, wait_o}, 32'd0);
    check("arid", {28'd0, arid_o}, 32'd0);
    check("arlen", {28'd0, arlen_o}, 32'd3);
    check("arsize", {29'd0, arsize_o}, 32'd2);
    check("arburst", {30'd0, arburst_o}, 32'd1);
    rst_i = 1'b0;
    tick();

    // Basic fill with latency check
    fill(32'h0000_1234, 32'h0000_00A0, 0, 1'b0, 4, -1, 1'b0, 1'b1, 1'b0);
    tick();
    // AR backpressure for 5 cycles, R beats with gaps
    fill(32'h0000_5678, 32'h0000_00B0, 5, 1'b1, 4, -1, 1'b0, 1'b0, 1'b1);
    tick();
    // SLVERR on beat 2, then a clean fill with err_o still sticky
    fill(32'h0000_0300, 32'h0000_00C0, 0, 1'b0, 4, 1, 1'b0, 1'b0, 1'b0);
    tick();
    fill(32'h0000_0310, 32'h0000_00C8, 0, 1'b0, 4, -1, 1'b0, 1'b0, 1'b0);
    tick();
    // Early RLAST on beat 2, then a normal fill
    fill(32'h0000_0400, 32'h0000_00D0, 0, 1'b0, 2, -1, 1'b0, 1'b0, 1'b0);
    tick();
    fill(32'h0000_0500, 32'h0000_00E0, 0, 1'b0, 4, -1, 1'b0, 1'b1, 1'b0);
    // Back-to-back: second request in first cycle wait_o is low
    fill(32'h0000_0600, 32'h0000_00F0, 0, 1'b0, 4, -1, 1'b0, 1'b0, 1'b0);
    fill(32'h0000_0040, 32'h0000_0010, 0, 1'b0, 4, -1, 1'b0, 1'b1, 1'b0);
    tick();
    // Reset after beat 1, then a clean fill
    fill(32'h0000_0700, 32'h0000_0077, 0, 1'b0, 1, -1, 1'b1, 1'b0, 1'b0);
    tick();
    fill(32'h0000_0808, 32'h0000_0088, 0, 1'b0, 4, -1, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    check("words_outstanding", 32'(exp_q.size()), 32'd0);
    check("ar_outstanding", 32'(ar_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_inst_read_master.md
Name: axi_inst_read_master

Overview:
- Downstream neighbour of the L1 instruction cache. It converts the cache's one-cycle line-fill request into a single AXI4 INCR read burst.
- Beats are returned to the cache one word at a time on a valid/wait handshake.
- Sits between the I$ miss path and the AXI interconnect as master 0; read channels only.

Parameters:
- BURST_LEN, 4, words per cache line; ARLEN = BURST_LEN-1.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant ARID driven on every request.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  line-fill request pulse from I$ (one cycle).
- addr_i  in  32  line-aligned fill address; bits[3:0] forced to 0 internally.
- wait_o  out  1  high while a fill is outstanding.
- out_valid_o  out  1  one returned word valid this cycle.
- out_o  out  32  returned word, burst order.
- araddr_o  out  32  AR address.
- arid_o  out  ID_W  AR ID.
- arlen_o  out  4  AR length.
- arsize_o  out  3  AR size.
- arburst_o  out  2  AR burst type.
- arvalid_o  out  1  AR valid.
- arready_i  in  1  AR ready.
- rid_i  in  ID_W  R ID.
- rdata_i  in  32  R data.
- rresp_i  in  2  R response.
- rlast_i  in  1  R last.
- rvalid_i  in  1  R valid.
- rready_o  out  1  R ready.
- err_o  out  1  sticky: non-OKAY RRESP or RLAST/beat-count mismatch seen.

Behaviour:
- Reset values:
  - state IDLE
  - arvalid_o=0, rready_o=0, out_valid_o=0, out_o=0
  - araddr_o=0, beat counter=0, err_o=0
  - wait_o follows its equation.
- Constant outputs: arid_o=AXI_ID, arlen_o=BURST_LEN-1 (4'd3), arsize_o=3'b010, arburst_o=2'b01 (INCR).
- FSM states:
  - IDLE:
    - On req_i: latch {addr_i[31:4],4'b0} into araddr_o; go to ADDR.
    - No AXI activity in the request cycle.
  - ADDR:
    - arvalid_o=1; araddr_o held stable until handshake.
    - On arvalid_o&&arready_i: go to DATA; clear beat counter.
  - DATA:
    - rready_o=1.
    - Each rvalid_i handshake registers rdata_i into out_o, sets out_valid_o=1 for exactly the next cycle, and increments the counter (2-bit wrap, modulo BURST_LEN).
    - On rlast_i handshake: go to IDLE.
- Latency and ordering:
  - out_valid_o lags the R handshake by one cycle.
  - Words arrive at the I$ in address order: word 0 (addr+0) first.
  - Minimum fill = 1 (ADDR) + 4 (DATA) + 1 = 6 cycles after req_i.
- wait_o = req_i | (state!=IDLE) | out_valid_o.
  - It therefore stays high through the cycle carrying the last word.
  - It falls the cycle after the last word.
  - The I$ gives out_valid priority over !wait, so no word is lost.
- req_i while state!=IDLE: ignored (protocol violation, simulation assertion fires). The I$ never issues a new fill before wait_o drops.
- rid_i != AXI_ID during DATA: data still accepted; assertion fires.
- Error handling (err_o is sticky until rst_i):
  - rresp_i != 2'b00 on any beat: word is still forwarded; err_o set.
  - rlast_i asserted with counter != BURST_LEN-1: burst ends early, FSM returns to IDLE, err_o set.
  - 4th beat without rlast_i: keep accepting until rlast_i; err_o set.
- Back-to-back fills:
  - A new req_i may arrive in the first cycle wait_o is low.
  - Next ARVALID is driven the following cycle.
- Reset mid-burst:
  - Next cycle all outputs return to reset values; FSM to IDLE.
  - Outstanding AXI beats are abandoned. System reset also resets the interconnect.

Optional Feature:
- Macro: INST_AXI_PERF_EN.
- Defined:
  - Integer counters for fills issued, total beats, and total cycles with wait_o high.
  - Cleared on rst_i.
  - A final block prints fill count, beat count and average fill latency (guarding divide by zero).
- Undefined: no counters or final block; functional behaviour identical.

Decomposition:
- Shared package inst_axi_pkg:
  - state enum AXI_RD_STATE_t {IDLE, ADDR, DATA}
  - constants AXI_BURST_INCR=2'b01, AXI_SIZE_WORD=3'b010, AXI_RESP_OKAY=2'b00
  - default BURST_LEN
- Single flat module; no sub-module is warranted (beat counter and output register are trivial).

Test Plan:
- Basic fill:
  - Stimulus: req_i pulse with addr_i=0x0000_1234; arready_i=1 immediately; R beats 0xA0,0xA1,0xA2,0xA3 back-to-back, rlast on 4th.
  - Response: araddr_o=0x0000_1230, arlen_o=3; out_valid_o high 4 cycles with 0xA0..0xA3 in order; wait_o falls 6 cycles after req_i; err_o=0.
- AR backpressure and R gaps:
  - Stimulus: arready_i low for 5 cycles; rvalid_i toggling 1,0,1,0.
  - Response: arvalid_o/araddr_o stable across stall; exactly 4 out_valid_o pulses; wait_o high throughout.
- Error response:
  - Stimulus: RRESP=2'b10 on beat 2.
  - Response: all 4 words delivered; err_o=1 from the cycle after beat 2 and persists into the next clean fill.
- Early RLAST:
  - Stimulus: rlast_i on beat 2.
  - Response: 2 out_valid_o pulses; FSM IDLE; err_o=1; next req_i serviced normally.
- Back-to-back fills:
  - Stimulus: second req_i (addr 0x40) in the first cycle wait_o=0.
  - Response: second ARVALID with araddr_o=0x40 the next cycle; no dropped or duplicated words.
- Reset mid-burst:
  - Stimulus: rst_i after beat 1.
  - Response: next cycle arvalid_o=rready_o=out_valid_o=err_o=0, wait_o=0; FSM IDLE.
